// File: rtl/excitation_pkg.sv
// Shared types and constants for the excitation burst generator.
package excitation_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
    localparam logic [31:0] LFSR_TAPS         = 32'h8020_0003;
    localparam logic [31:0] DEFAULT_SEED      = 32'hACE1_2468;
    localparam int          MIN_BURST_DEFAULT = 4;
    localparam int          SCALE_SHIFT       = 7;

endpackage

// File: rtl/lfsr32_galois.sv
// Free-running 32-bit Galois LFSR; advances every clock, reloads seed on reset.
module lfsr32_galois
    import excitation_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] seed,
    output logic [31:0] out
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out <= seed;
        end else if (out[0]) begin
            out <= (out >> 1) ^ LFSR_TAPS;
        end else begin
            out <= out >> 1;
        end
    end

endmodule

// File: rtl/excitation_burst_gen.sv
// Note-triggered, velocity-scaled noise burst for the plucked-string stage.
// Outputs are registered from the FSM state, so trig/busy/dnoise move together.
module excitation_burst_gen
    import excitation_pkg::*;
#(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] LFSR_SEED = DEFAULT_SEED,
    parameter int          MIN_BURST = MIN_BURST_DEFAULT
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             note_on,
    input  logic [6:0]       velocity,
    input  logic [1:0]       tone,
    input  logic [11:0]      burst_len,
    output logic             trig,
    output logic             busy,
    output logic [WIDTH-1:0] dnoise
);

    function automatic logic signed [WIDTH-1:0] scale_noise(input logic [31:0] r,
                                                            input logic [6:0]  v);
        logic signed [38:0] prod;
        prod = $signed({{7{r[31]}}, r}) * $signed({32'd0, v});
        return WIDTH'(prod >>> SCALE_SHIFT);
    endfunction

    // One-pole low-pass step; the extra bit keeps x - y from wrapping.
    function automatic logic signed [WIDTH-1:0] lowpass_step(input logic signed [WIDTH-1:0] x,
                                                             input logic signed [WIDTH-1:0] y,
                                                             input logic [1:0]              k);
        logic signed [WIDTH:0] diff;
        diff = {x[WIDTH-1], x} - {y[WIDTH-1], y};
        return y + WIDTH'(diff >>> k);
    endfunction

    state_t                  state, state_nxt;
    logic [11:0]             cnt;
    logic [11:0]             len_q;
    logic [11:0]             len_in;
    logic [6:0]              vel_q;
    logic [31:0]             lfsr;
    logic signed [WIDTH-1:0] x_p0;
    logic signed [WIDTH-1:0] y_q;
    logic signed [WIDTH-1:0] y_nxt;
    logic signed [WIDTH-1:0] s_p0;

    lfsr32_galois u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .seed    (LFSR_SEED),
        .out     (lfsr)
    );

    assign len_in = (burst_len < 12'(MIN_BURST)) ? 12'(MIN_BURST) : burst_len;
    assign x_p0   = scale_noise(lfsr, vel_q);
    assign y_nxt  = lowpass_step(x_p0, y_q, tone);
    assign s_p0   = (tone == 2'd0) ? x_p0 : y_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (note_on) state_nxt = BURST;
            BURST: begin
                if (note_on)                    state_nxt = BURST;
                else if (cnt == len_q - 12'd1)  state_nxt = DONE;
            end
            DONE:    state_nxt = note_on ? BURST : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stage p0 -> p1: control, latches, filter state and output register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            len_q  <= 12'(MIN_BURST);
            vel_q  <= '0;
            y_q    <= '0;
            trig   <= 1'b0;
            busy   <= 1'b0;
            dnoise <= '0;
        end else begin
            state  <= state_nxt;
            trig   <= (state == BURST);
            busy   <= (state != IDLE);
            dnoise <= (state == BURST) ? s_p0 : '0;

            if (state == BURST && tone != 2'd0) y_q <= y_nxt;

            if (note_on) begin
                vel_q <= velocity;
                len_q <= len_in;
                cnt   <= '0;
                // A restart keeps the filter history so the tone stays continuous.
                if (state != BURST) y_q <= '0;
            end else if (state == BURST) begin
                cnt <= cnt + 12'd1;
            end
        end
    end

endmodule

// File: tb/tb_excitation_burst_gen.sv
// Directed/randomized bench for excitation_burst_gen against a behavioural model.
module tb_excitation_burst_gen;

    localparam int          WIDTH = 32;
    localparam logic [31:0] SEED  = 32'hACE1_2468;
    localparam int          MINB  = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             note_on;
    logic [6:0]       velocity;
    logic [1:0]       tone;
    logic [11:0]      burst_len;
    logic             trig;
    logic             busy;
    logic [WIDTH-1:0] dnoise;

    always #5 clk = ~clk;

    excitation_burst_gen #(
        .WIDTH     (WIDTH),
        .LFSR_SEED (SEED),
        .MIN_BURST (MINB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .note_on   (note_on),
        .velocity  (velocity),
        .tone      (tone),
        .burst_len (burst_len),
        .trig      (trig),
        .busy      (busy),
        .dnoise    (dnoise)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: remaining burst cycles plus a pending-done flag.
    logic [31:0]      m_lfsr;
    int               m_rem;
    bit               m_done;
    logic [6:0]       m_vel;
    longint           m_y;
    logic             exp_trig;
    logic             exp_busy;
    logic [WIDTH-1:0] exp_dnoise;

    function automatic longint scale(input logic [31:0] r, input logic [6:0] v);
        longint p;
        p = longint'($signed(r)) * longint'(v);
        return p >>> 7;
    endfunction

    function automatic logic [31:0] lfsr_next(input logic [31:0] r);
        return r[0] ? ((r >> 1) ^ 32'h8020_0003) : (r >> 1);
    endfunction

    always @(posedge clk) begin
        longint x;
        longint d;
        bit     in_b;
        if (!reset_n) begin
            m_lfsr = SEED; m_rem = 0; m_done = 0; m_vel = '0; m_y = 0;
            exp_trig = 1'b0; exp_busy = 1'b0; exp_dnoise = '0;
        end else begin
            in_b       = (m_rem > 0);
            exp_trig   = in_b;
            exp_busy   = in_b || m_done;
            exp_dnoise = '0;
            if (in_b) begin
                x = scale(m_lfsr, m_vel);
                if (tone == 2'd0) begin
                    exp_dnoise = x[31:0];
                end else begin
                    d   = x - m_y;
                    m_y = m_y + (d >>> tone);
                    exp_dnoise = m_y[31:0];
                end
            end
            if (note_on) begin
                m_vel  = velocity;
                m_rem  = (burst_len < 12'(MINB)) ? MINB : int'(burst_len);
                if (!in_b) m_y = 0;
                m_done = 0;
            end else if (in_b) begin
                m_rem  = m_rem - 1;
                m_done = (m_rem == 0);
            end else begin
                m_done = 0;
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
    end

    // Per-run statistics
    int          cyc, first_rise, trig_cnt, busy_cnt, done_cnt, rises, stray, nz_cnt;
    logic        prev_trig;
    real         sum, sumsq;
    bit          rec_ref, cmp_ref;
    logic [31:0] ref_burst[$];
    int          ref_idx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clr_stats();
        cyc = 0; first_rise = -1; trig_cnt = 0; busy_cnt = 0; done_cnt = 0;
        rises = 0; stray = 0; nz_cnt = 0; prev_trig = 1'b0; sum = 0.0; sumsq = 0.0;
    endtask

    task automatic cycle();
        real v;
        @(posedge clk);
        @(negedge clk);
        cyc++;
        chk("trig", 64'(trig), 64'(exp_trig));
        chk("busy", 64'(busy), 64'(exp_busy));
        chk("dnoise", 64'(dnoise), 64'(exp_dnoise));
        if (trig === 1'b1) begin
            trig_cnt++;
            if (prev_trig !== 1'b1) begin
                rises++;
                if (first_rise < 0) first_rise = cyc;
            end
            v = real'($signed(dnoise));
            sum += v;
            sumsq += v * v;
            if (rec_ref) ref_burst.push_back(exp_dnoise);
            if (cmp_ref && ref_idx < ref_burst.size()) begin
                chk("replay", 64'(dnoise), 64'(ref_burst[ref_idx]));
                ref_idx++;
            end
        end
        if (busy === 1'b1) busy_cnt++;
        if (busy === 1'b1 && trig === 1'b0) done_cnt++;
        if (dnoise !== '0) nz_cnt++;
        if (dnoise !== '0 && trig !== 1'b1) stray++;
        prev_trig = trig;
    endtask

    task automatic fresh();
        reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
        repeat (3) cycle();
    endtask

    task automatic pulse(input logic [6:0] v, input logic [1:0] t, input logic [11:0] l);
        note_on = 1'b1; velocity = v; tone = t; burst_len = l;
        cycle();
        note_on = 1'b0;
        velocity = 7'($urandom_range(0, 127));
        burst_len = 12'($urandom_range(0, 4095));
        cyc = 0;
    endtask

    real var_lp, var_wh, mean;

    initial begin
        reset_n = 1'b0; note_on = 1'b0; velocity = '0; tone = '0; burst_len = '0;
        rec_ref = 1'b0; cmp_ref = 1'b0; ref_idx = 0;
        clr_stats();

        // Reset state
        repeat (2) cycle();
        chk("rst_trig", 64'(trig), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_dnoise", 64'(dnoise), 64'd0);

        // Full-velocity white burst, recorded for the replay after reset
        fresh(); clr_stats();
        rec_ref = 1'b1;
        pulse(7'd127, 2'd0, 12'd100);
        repeat (110) cycle();
        rec_ref = 1'b0;
        chk("b100_trig", 64'(trig_cnt), 64'd100);
        chk("b100_busy", 64'(busy_cnt), 64'd101);
        chk("b100_first", 64'(first_rise), 64'd1);
        chk("b100_done", 64'(done_cnt), 64'd1);
        chk("b100_stray", 64'(stray), 64'd0);

        // Zero velocity gives a silent burst
        fresh(); clr_stats();
        pulse(7'd0, 2'(tone), 12'd50);
        repeat (60) cycle();
        chk("v0_trig", 64'(trig_cnt), 64'd50);
        chk("v0_nz", 64'(nz_cnt), 64'd0);

        // Short lengths are clamped to the minimum
        fresh(); clr_stats();
        pulse(7'($urandom_range(1, 127)), 2'd0, 12'd2);
        repeat (10) cycle();
        chk("len2_trig", 64'(trig_cnt), 64'd4);
        fresh(); clr_stats();
        pulse(7'($urandom_range(1, 127)), 2'd0, 12'd0);
        repeat (10) cycle();
        chk("len0_trig", 64'(trig_cnt), 64'd4);
        chk("len0_busy", 64'(busy_cnt), 64'd5);

        // Restart 60 cycles into a 100-cycle burst with a 30-cycle burst
        fresh(); clr_stats();
        pulse(7'($urandom_range(1, 127)), 2'd1, 12'd100);
        repeat (59) cycle();
        pulse(7'($urandom_range(1, 127)), 2'd1, 12'd30);
        repeat (40) cycle();
        chk("rs_trig", 64'(trig_cnt), 64'd90);
        chk("rs_rises", 64'(rises), 64'd1);
        chk("rs_done", 64'(done_cnt), 64'd1);
        chk("rs_busy", 64'(busy_cnt), 64'd91);

        // Low-passed burst must have lower variance than white over the same window
        fresh(); clr_stats();
        pulse(7'd64, 2'd2, 12'd200);
        repeat (210) cycle();
        chk("lp_trig", 64'(trig_cnt), 64'd200);
        mean = sum / 200.0;
        var_lp = sumsq / 200.0 - mean * mean;
        fresh(); clr_stats();
        pulse(7'd64, 2'd0, 12'd200);
        repeat (210) cycle();
        mean = sum / 200.0;
        var_wh = sumsq / 200.0 - mean * mean;
        chk("lp_var_lower", 64'(var_lp < var_wh), 64'd1);

        // Reset mid-burst, then replay the first burst from the seed
        fresh(); clr_stats();
        ref_idx = 0; cmp_ref = 1'b1;
        pulse(7'd127, 2'd0, 12'd100);
        repeat (9) cycle();
        reset_n = 1'b0;
        cycle();
        chk("abort_trig", 64'(trig), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_dnoise", 64'(dnoise), 64'd0);
        reset_n = 1'b1;
        repeat (3) cycle();
        clr_stats();
        ref_idx = 0;
        pulse(7'd127, 2'd0, 12'd100);
        repeat (110) cycle();
        cmp_ref = 1'b0;
        chk("replay_len", 64'(ref_idx), 64'd100);
        chk("replay_trig", 64'(trig_cnt), 64'd100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/excitation_burst_gen.md
# excitation_burst_gen

Upstream excitation source for the plucked-string delay-line stage. On a note event it produces a velocity-scaled, optionally low-passed pseudo-random noise burst on `dnoise` and holds `trig` high for the burst duration, so the string stage loads the burst into its delay line. Outside a burst `dnoise` is zero and `trig` is low. It sits between the key/sequencer logic and the string stage's `dnoise`/`trig` inputs.

## Interface
- `WIDTH`, 32, sample width of `dnoise` (signed two's complement).
- `LFSR_SEED`, 32'hACE1_2468, non-zero LFSR reset value.
- `MIN_BURST`, 4, minimum burst length in clk cycles.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  reset, synchronous, active-low.
- `note_on`  in  1  one-cycle note request pulse.
- `velocity`  in  7  unsigned amplitude, 0..127; sampled with `note_on`.
- `tone`  in  2  noise colour: 0 = white, 1..3 = one-pole low-pass with shift k = tone.
- `burst_len`  in  12  burst length in cycles; sampled with `note_on`.
- `trig`  out  1  high for the whole burst; drives string-stage `trig`.
- `busy`  out  1  high in BURST or DONE.
- `dnoise`  out  WIDTH  signed excitation sample; 0 outside BURST.

## Operation
- States: IDLE, BURST, DONE.
- IDLE: `note_on`=1 -> BURST; latch `velocity`, latch len = max(`burst_len`, MIN_BURST); clear burst counter, clear low-pass accumulator y.
- BURST: counter increments each cycle; when counter = len-1 -> DONE. `note_on`=1 in BURST (any cycle, including the last) restarts: relatch velocity/len, counter to 0, stay in BURST; y is not cleared.
- DONE: one cycle, `trig`=0, `dnoise`=0; -> IDLE. `note_on` in DONE behaves as in IDLE (-> BURST).
- LFSR: 32-bit Galois, taps 32'h8020_0003 (x^32+x^22+x^2+x+1), shifts every clk regardless of state; reset loads LFSR_SEED. Never reaches zero.
- Scaling: x = (signed lfsr × {1'b0, vel}) >>> 7, 39-bit product, truncated to WIDTH (no overflow possible: |x| < 2^31).
- Tone: tone=0 -> s = x; else y <= y + ((x − y) >>> tone), s = y; 33-bit internal subtraction, y held at WIDTH.
- `dnoise` = s registered in BURST, else 0. `tone` is read live (not latched).

## Timing
- Reset (reset_n=0 at an edge): state IDLE, `trig`=0, `busy`=0, `dnoise`=0, y=0, counter=0, LFSR=LFSR_SEED. Reset mid-burst aborts: outputs at reset values after that edge.
- `note_on` sampled at edge N -> `trig`=1, `busy`=1, first valid `dnoise` visible after edge N+1 (1-cycle latency).
- `trig` high exactly len consecutive cycles; `dnoise` non-zero only in those cycles (unless x=0).
- Restart extends `trig` with no low gap; total high time = cycles before restart + new len.
- `busy` high len+1 cycles (BURST + DONE) per un-restarted burst.
- `note_on` with reset_n=0 at same edge: reset wins.

## Structure
- Package `excitation_pkg`: state enum (IDLE/BURST/DONE), LFSR tap constant, default seed, MIN_BURST default, scaling shift (7).
- One sub-module: `lfsr32_galois` (clk, reset_n, seed, out), free-running.
- Top holds FSM, counter, latches, scaler, low-pass, output register.

## Test plan
- Reset, then `note_on` with velocity=127, tone=0, burst_len=100 -> `trig` high exactly 100 cycles starting 1 cycle after pulse; `dnoise` matches bit-exact model (lfsr×127)>>>7; `busy` high 101 cycles; `dnoise`=0 afterwards.
- velocity=0, burst_len=50 -> `trig` high 50 cycles, `dnoise`=0 throughout.
- burst_len=2 and burst_len=0 -> `trig` high 4 cycles each.
- burst_len=100, second `note_on` (burst_len=30) at burst cycle 60 -> `trig` continuously high 90 cycles, single DONE at end.
- tone=2, velocity=64, burst_len=200 -> `dnoise` equals model y += (x−y)>>>2 from y=0; variance below tone=0 run over same LFSR window.
- reset_n=0 at burst cycle 10 of 100 -> next cycle `trig`=0, `busy`=0, `dnoise`=0; following `note_on` reproduces the first-burst sequence from LFSR_SEED timing.
